// File: rtl/alu_pkg.sv
// Shared definitions for the ALU reservation station.
//   - one-hot ALU op bit positions and the op vector width
//   - per-operand and per-slot storage types
//   - operand helpers used at issue time and while snooping the CDB
// Tags are held internally at RS_TAG_W bits. The station's TAG_W must not exceed it.
package alu_pkg;

  localparam int ALU_OP_W = 8;
  localparam int DATA_W   = 32;
  localparam int RS_TAG_W = 4;

  localparam int OP_ADD  = 0;
  localparam int OP_SLL  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SRL  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_AND  = 7;

  typedef struct packed {
    logic                waiting;
    logic [RS_TAG_W-1:0] tag;
    logic [DATA_W-1:0]   value;
  } rs_operand_t;

  typedef struct packed {
    logic                busy;
    logic [ALU_OP_W-1:0] op;
    logic                funct7;
    logic [RS_TAG_W-1:0] dst_tag;
    rs_operand_t         opnd1;
    rs_operand_t         opnd2;
  } rs_slot_t;

  // Operand as captured at issue. A producer broadcasting in the same cycle
  // is forwarded directly, so the operand never waits on a tag already gone by.
  function automatic rs_operand_t issue_operand(
    input logic                q_wait,
    input logic [RS_TAG_W-1:0] q_tag,
    input logic [DATA_W-1:0]   v,
    input logic                cdb_valid,
    input logic [RS_TAG_W-1:0] cdb_tag,
    input logic [DATA_W-1:0]   cdb_value
  );
    rs_operand_t o;
    o.tag     = q_tag;
    o.waiting = q_wait;
    o.value   = v;
    if (q_wait && cdb_valid && (cdb_tag == q_tag)) begin
      o.waiting = 1'b0;
      o.value   = cdb_value;
    end
    return o;
  endfunction

  // Held operand after observing one CDB broadcast.
  function automatic rs_operand_t snoop_operand(
    input rs_operand_t         o,
    input logic                cdb_valid,
    input logic [RS_TAG_W-1:0] cdb_tag,
    input logic [DATA_W-1:0]   cdb_value
  );
    rs_operand_t r;
    r = o;
    if (o.waiting && cdb_valid && (o.tag == cdb_tag)) begin
      r.waiting = 1'b0;
      r.value   = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_slot.sv
// One reservation-station slot: storage, issue-time CDB bypass, CDB capture.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears busy only)
//   write               load the issue fields into this slot at the edge
//   clear               slot is being dispatched, free it at the edge
//   issue_*             decoded instruction fields from the decoder
//   cdb_valid/tag/value common data bus broadcast
//   busy, ready         occupancy and "both operands present"
//   op, funct7, dst_tag, v1, v2   stored instruction for dispatch
module rs_slot
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic                clear,
  input  logic [ALU_OP_W-1:0] issue_op,
  input  logic                issue_funct7,
  input  logic [TAG_W-1:0]    issue_dst_tag,
  input  logic                issue_q1_wait,
  input  logic [TAG_W-1:0]    issue_q1_tag,
  input  logic [DATA_W-1:0]   issue_v1,
  input  logic                issue_q2_wait,
  input  logic [TAG_W-1:0]    issue_q2_tag,
  input  logic [DATA_W-1:0]   issue_v2,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATA_W-1:0]   cdb_value,
  output logic                busy,
  output logic                ready,
  output logic [ALU_OP_W-1:0] op,
  output logic                funct7,
  output logic [TAG_W-1:0]    dst_tag,
  output logic [DATA_W-1:0]   v1,
  output logic [DATA_W-1:0]   v2
);

  rs_slot_t            slot;
  logic [RS_TAG_W-1:0] cdb_tag_w;

  assign cdb_tag_w = RS_TAG_W'(cdb_tag);

  // Only busy is reset; payload is qualified by busy everywhere it is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot.busy <= 1'b0;
    end else if (write) begin
      slot.busy    <= 1'b1;
      slot.op      <= issue_op;
      slot.funct7  <= issue_funct7;
      slot.dst_tag <= RS_TAG_W'(issue_dst_tag);
      slot.opnd1   <= issue_operand(issue_q1_wait, RS_TAG_W'(issue_q1_tag), issue_v1,
                                    cdb_valid, cdb_tag_w, cdb_value);
      slot.opnd2   <= issue_operand(issue_q2_wait, RS_TAG_W'(issue_q2_tag), issue_v2,
                                    cdb_valid, cdb_tag_w, cdb_value);
    end else begin
      if (clear) begin
        slot.busy <= 1'b0;
      end
      if (slot.busy) begin
        slot.opnd1 <= snoop_operand(slot.opnd1, cdb_valid, cdb_tag_w, cdb_value);
        slot.opnd2 <= snoop_operand(slot.opnd2, cdb_valid, cdb_tag_w, cdb_value);
      end
    end
  end

  assign busy    = slot.busy;
  assign ready   = slot.busy && !slot.opnd1.waiting && !slot.opnd2.waiting;
  assign op      = slot.op;
  assign funct7  = slot.funct7;
  assign dst_tag = TAG_W'(slot.dst_tag);
  assign v1      = slot.opnd1.value;
  assign v2      = slot.opnd2.value;

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the integer ALU.
// Holds up to ENTRIES decoded instructions, snoops the CDB for missing
// operands and dispatches the lowest-index ready slot each cycle. The
// destination tag is registered one cycle so it lines up with the ALU's
// registered result for the {tag, result} broadcast.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   issue_valid / issue_ready       decoder handshake (ready = a slot is free)
//   issue_op, issue_funct7          one-hot op and sub/sra flag
//   issue_dst_tag                   tag of the result
//   issue_qN_wait/tag, issue_vN     operand N: pending producer tag or value
//   cdb_valid/tag/value             common data bus broadcast
//   alu_in1/in2/op/funct7           dispatch to the ALU (all zero when idle)
//   wb_valid, wb_tag                tag of the ALU result presented this cycle
module alu_reservation_station
  import alu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ALU_OP_W-1:0] issue_op,
  input  logic                issue_funct7,
  input  logic [TAG_W-1:0]    issue_dst_tag,
  input  logic                issue_q1_wait,
  input  logic [TAG_W-1:0]    issue_q1_tag,
  input  logic [DATA_W-1:0]   issue_v1,
  input  logic                issue_q2_wait,
  input  logic [TAG_W-1:0]    issue_q2_tag,
  input  logic [DATA_W-1:0]   issue_v2,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATA_W-1:0]   cdb_value,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_funct7,
  output logic                wb_valid,
  output logic [TAG_W-1:0]    wb_tag
);

  function automatic logic [ENTRIES-1:0] pick_lowest(input logic [ENTRIES-1:0] req);
    logic [ENTRIES-1:0] grant;
    grant = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

  logic [ENTRIES-1:0]  busy_vec;
  logic [ENTRIES-1:0]  ready_vec;
  logic [ENTRIES-1:0]  f7_vec;
  logic [ENTRIES-1:0]  free_grant;
  logic [ENTRIES-1:0]  disp_grant;
  logic [ALU_OP_W-1:0] op_arr  [ENTRIES];
  logic [TAG_W-1:0]    tag_arr [ENTRIES];
  logic [DATA_W-1:0]   v1_arr  [ENTRIES];
  logic [DATA_W-1:0]   v2_arr  [ENTRIES];
  logic                issue_fire;
  logic                vld_p0;
  logic [TAG_W-1:0]    tag_p0;
  logic                vld_p1;
  logic [TAG_W-1:0]    tag_p1;

  // Both pickers look at registered state only, so a slot freed by dispatch
  // is not reused until the next cycle and issue never hits the dispatching slot.
  assign issue_ready = ~&busy_vec;
  assign issue_fire  = issue_valid && issue_ready;
  assign free_grant  = pick_lowest(~busy_vec);
  assign disp_grant  = pick_lowest(ready_vec);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    rs_slot #(.TAG_W(TAG_W)) u_slot (
      .clk           (clk),
      .rst           (rst),
      .write         (issue_fire && free_grant[g]),
      .clear         (disp_grant[g]),
      .issue_op      (issue_op),
      .issue_funct7  (issue_funct7),
      .issue_dst_tag (issue_dst_tag),
      .issue_q1_wait (issue_q1_wait),
      .issue_q1_tag  (issue_q1_tag),
      .issue_v1      (issue_v1),
      .issue_q2_wait (issue_q2_wait),
      .issue_q2_tag  (issue_q2_tag),
      .issue_v2      (issue_v2),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_value     (cdb_value),
      .busy          (busy_vec[g]),
      .ready         (ready_vec[g]),
      .op            (op_arr[g]),
      .funct7        (f7_vec[g]),
      .dst_tag       (tag_arr[g]),
      .v1            (v1_arr[g]),
      .v2            (v2_arr[g])
    );
  end

  // ---- p0: dispatch select from registered slot state ----
  always_comb begin
    alu_in1    = '0;
    alu_in2    = '0;
    alu_op     = '0;
    alu_funct7 = 1'b0;
    tag_p0     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (disp_grant[i]) begin
        alu_in1    = v1_arr[i];
        alu_in2    = v2_arr[i];
        alu_op     = op_arr[i];
        alu_funct7 = f7_vec[i];
        tag_p0     = tag_arr[i];
      end
    end
  end

  assign vld_p0 = |ready_vec;

  // ---- p1: writeback tag, aligned with the ALU's registered result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      tag_p1 <= tag_p0;
    end
  end

  assign wb_valid = vld_p1;
  assign wb_tag   = tag_p1;

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

  localparam int ENTRIES = 4;
  localparam int TAG_W   = 4;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [7:0]       issue_op;
  logic             issue_funct7;
  logic [TAG_W-1:0] issue_dst_tag;
  logic             issue_q1_wait;
  logic [TAG_W-1:0] issue_q1_tag;
  logic [31:0]      issue_v1;
  logic             issue_q2_wait;
  logic [TAG_W-1:0] issue_q2_tag;
  logic [31:0]      issue_v2;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_in2;
  logic [7:0]       alu_op;
  logic             alu_funct7;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;

  alu_reservation_station #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_funct7(issue_funct7), .issue_dst_tag(issue_dst_tag),
    .issue_q1_wait(issue_q1_wait), .issue_q1_tag(issue_q1_tag), .issue_v1(issue_v1),
    .issue_q2_wait(issue_q2_wait), .issue_q2_tag(issue_q2_tag), .issue_v2(issue_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_funct7(alu_funct7),
    .wb_valid(wb_valid), .wb_tag(wb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a table of pending instructions plus expected-response queues.
  typedef struct {
    bit             busy;
    bit [7:0]       op;
    bit             f7;
    bit [TAG_W-1:0] dst;
    bit             w1;
    bit [TAG_W-1:0] t1;
    bit [31:0]      v1;
    bit             w2;
    bit [TAG_W-1:0] t2;
    bit [31:0]      v2;
  } mslot_t;

  typedef struct {
    bit [31:0] in1;
    bit [31:0] in2;
    bit [7:0]  op;
    bit        f7;
  } disp_t;

  typedef struct {
    bit [TAG_W-1:0] tag;
    int             due;
  } wb_t;

  mslot_t m [ENTRIES];
  disp_t  exp_disp [$];
  wb_t    exp_wb [$];
  bit     exp_ready;
  bit     armed;
  int     cyc;
  int     checks;
  int     failures;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Model: apply the inputs seen at this edge, then predict this cycle's outputs.
  always @(posedge clk) begin
    int d;
    int f;
    cyc++;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m[i].busy = 0;
      armed = 1;
      while (exp_wb.size() > 0 && exp_wb[exp_wb.size()-1].due == cyc) void'(exp_wb.pop_back());
    end else if (armed) begin
      d = -1;
      f = -1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (d < 0 && m[i].busy && !m[i].w1 && !m[i].w2) d = i;
        if (f < 0 && !m[i].busy) f = i;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (m[i].busy && cdb_valid) begin
          if (m[i].w1 && m[i].t1 == cdb_tag) begin m[i].w1 = 0; m[i].v1 = cdb_value; end
          if (m[i].w2 && m[i].t2 == cdb_tag) begin m[i].w2 = 0; m[i].v2 = cdb_value; end
        end
      end
      if (d >= 0) m[d].busy = 0;
      if (issue_valid && f >= 0) begin
        m[f].busy = 1;
        m[f].op   = issue_op;
        m[f].f7   = issue_funct7;
        m[f].dst  = issue_dst_tag;
        m[f].t1   = issue_q1_tag;
        m[f].t2   = issue_q2_tag;
        m[f].w1   = issue_q1_wait;
        m[f].v1   = issue_v1;
        m[f].w2   = issue_q2_wait;
        m[f].v2   = issue_v2;
        if (issue_q1_wait && cdb_valid && cdb_tag == issue_q1_tag) begin
          m[f].w1 = 0; m[f].v1 = cdb_value;
        end
        if (issue_q2_wait && cdb_valid && cdb_tag == issue_q2_tag) begin
          m[f].w2 = 0; m[f].v2 = cdb_value;
        end
      end
    end
    if (armed) begin
      exp_ready = 0;
      d = -1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (!m[i].busy) exp_ready = 1;
        if (d < 0 && m[i].busy && !m[i].w1 && !m[i].w2) d = i;
      end
      if (d >= 0) begin
        exp_disp.push_back('{in1: m[d].v1, in2: m[d].v2, op: m[d].op, f7: m[d].f7});
        exp_wb.push_back('{tag: m[d].dst, due: cyc + 1});
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    disp_t e;
    wb_t   w;
    if (armed) begin
      chk("issue_ready", 64'(issue_ready), 64'(exp_ready));
      if (alu_op != 8'h00) begin
        if (exp_disp.size() == 0) begin
          chk("unexpected_dispatch_op", 64'(alu_op), 64'h0);
        end else begin
          e = exp_disp.pop_front();
          chk("alu_op", 64'(alu_op), 64'(e.op));
          chk("alu_in1", 64'(alu_in1), 64'(e.in1));
          chk("alu_in2", 64'(alu_in2), 64'(e.in2));
          chk("alu_funct7", 64'(alu_funct7), 64'(e.f7));
        end
      end else begin
        chk("idle_alu_outputs", {31'h0, alu_funct7, alu_in1}, 64'h0);
        chk("idle_alu_in2", 64'(alu_in2), 64'h0);
        if (exp_disp.size() != 0) begin
          e = exp_disp.pop_front();
          chk("missed_dispatch_op", 64'(alu_op), 64'(e.op));
        end
      end
      if (exp_wb.size() > 0 && exp_wb[0].due == cyc) begin
        w = exp_wb.pop_front();
        chk("wb_valid", 64'(wb_valid), 64'h1);
        chk("wb_tag", 64'(wb_tag), 64'(w.tag));
      end else begin
        chk("wb_valid_idle", 64'(wb_valid), 64'h0);
      end
    end
  end

  task automatic set_idle();
    rst           = 1'b0;
    issue_valid   = 1'b0;
    issue_op      = 8'h00;
    issue_funct7  = 1'b0;
    issue_dst_tag = '0;
    issue_q1_wait = 1'b0;
    issue_q1_tag  = '0;
    issue_v1      = 32'h0;
    issue_q2_wait = 1'b0;
    issue_q2_tag  = '0;
    issue_v2      = 32'h0;
    cdb_valid     = 1'b0;
    cdb_tag       = '0;
    cdb_value     = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic issue(input logic [7:0] op, input logic f7, input logic [TAG_W-1:0] dst,
                       input logic w1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                       input logic w2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_funct7  = f7;
    issue_dst_tag = dst;
    issue_q1_wait = w1;
    issue_q1_tag  = t1;
    issue_v1      = v1;
    issue_q2_wait = w2;
    issue_q2_tag  = t2;
    issue_v2      = v2;
    cycle();
  endtask

  task automatic bcast(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    armed    = 0;
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    chk("reset_wb_tag", 64'(wb_tag), 64'h0);
    chk("reset_issue_ready", 64'(issue_ready), 64'h1);
    chk("reset_alu_op", 64'(alu_op), 64'h0);
    @(posedge clk);
    #1;

    // Plain add with both operands present.
    issue(8'h01, 1'b0, 4'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    idle(3);

    // Sub waiting on tag 3, released by a later broadcast.
    issue(8'h01, 1'b1, 4'd2, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'd2);
    idle(1);
    bcast(4'd3, 32'd10);
    idle(3);

    // Both operands bypassed from a same-cycle broadcast.
    cdb_valid = 1'b1;
    cdb_tag   = 4'd6;
    cdb_value = 32'h20;
    issue(8'h01, 1'b0, 4'd4, 1'b1, 4'd6, 32'h0, 1'b1, 4'd6, 32'h0);
    idle(3);

    // Fill every slot, try a fifth issue, then release slot 2 first.
    issue(8'h02, 1'b0, 4'd8,  1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'h11);
    issue(8'h04, 1'b0, 4'd9,  1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'h22);
    issue(8'h10, 1'b0, 4'd10, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'h33);
    issue(8'h80, 1'b0, 4'd11, 1'b0, 4'd0, 32'h1, 1'b1, 4'd4, 32'h0);
    issue(8'h40, 1'b0, 4'd12, 1'b0, 4'd0, 32'h5, 1'b0, 4'd0, 32'h6);
    bcast(4'd3, 32'h3333);
    idle(2);
    bcast(4'd1, 32'h1111);
    bcast(4'd2, 32'h2222);
    bcast(4'd4, 32'h4444);
    idle(4);

    // Slots 1 and 3 released by the same broadcast.
    issue(8'h01, 1'b0, 4'd1, 1'b1, 4'd10, 32'h0, 1'b0, 4'd0, 32'h1);
    issue(8'h08, 1'b0, 4'd2, 1'b1, 4'd9,  32'h0, 1'b0, 4'd0, 32'h2);
    issue(8'h20, 1'b1, 4'd3, 1'b1, 4'd11, 32'h0, 1'b0, 4'd0, 32'h3);
    issue(8'h10, 1'b0, 4'd4, 1'b0, 4'd0,  32'h4, 1'b1, 4'd9, 32'h0);
    bcast(4'd9, 32'h99);
    idle(3);
    bcast(4'd10, 32'hAA);
    bcast(4'd11, 32'hBB);
    idle(4);

    // Reset the cycle after a dispatch.
    issue(8'h01, 1'b0, 4'd13, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    cycle();
    rst = 1'b1;
    cycle();
    @(negedge clk);
    chk("post_reset_wb_valid", 64'(wb_valid), 64'h0);
    chk("post_reset_issue_ready", 64'(issue_ready), 64'h1);
    chk("post_reset_alu_op", 64'(alu_op), 64'h0);
    @(posedge clk);
    #1;

    // Reset in the same cycle as a dispatch.
    issue(8'h02, 1'b0, 4'd14, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4);
    rst = 1'b1;
    cycle();
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      issue_valid   = ($urandom_range(0, 99) < 55);
      issue_op      = 8'h01 << $urandom_range(0, 7);
      issue_funct7  = 1'($urandom_range(0, 1));
      issue_dst_tag = 4'($urandom_range(0, 15));
      issue_q1_wait = ($urandom_range(0, 99) < 40);
      issue_q1_tag  = 4'($urandom_range(0, 15));
      issue_v1      = $urandom;
      issue_q2_wait = ($urandom_range(0, 99) < 40);
      issue_q2_tag  = 4'($urandom_range(0, 15));
      issue_v2      = $urandom;
      cdb_valid     = ($urandom_range(0, 99) < 50);
      cdb_tag       = 4'($urandom_range(0, 15));
      cdb_value     = $urandom;
      rst           = ($urandom_range(0, 299) == 0);
      cycle();
    end

    // Drain: broadcast every tag so all held instructions complete.
    for (int t = 0; t < 16; t++) bcast(4'(t), $urandom);
    idle(8);
    chk("drain_dispatch_queue", 64'(exp_disp.size()), 64'h0);
    chk("drain_wb_queue", 64'(exp_wb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side partner of the integer ALU in the Tomasulo core. Holds up to ENTRIES decoded ALU instructions and snoops the CDB for missing operands.
- Each cycle it dispatches at most one fully-ready instruction to the ALU as operands, one-hot op and funct7 flag.
- One cycle after dispatch it emits the destination tag, aligned with the ALU's registered result, so writeback can broadcast {tag, result}.

Parameters:
- ENTRIES, 4, number of station slots (2..8).
- TAG_W, 4, width of ROB/producer tags.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  decoder presents an instruction
- issue_ready  out  1  at least one free slot
- issue_op  in  8  one-hot ALU op: b0 add/sub, b1 sll, b2 slt, b3 sltu, b4 xor, b5 srl/sra, b6 or, b7 and
- issue_funct7  in  1  selects sub (b0) / sra (b5)
- issue_dst_tag  in  TAG_W  tag of the result
- issue_q1_wait  in  1  operand 1 pending on issue_q1_tag
- issue_q1_tag  in  TAG_W  producer tag, operand 1
- issue_v1  in  32  operand 1 value, when not waiting
- issue_q2_wait, issue_q2_tag, issue_v2  in  1/TAG_W/32  same for operand 2
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  32  broadcast value
- alu_in1  out  32  operand 1 to the ALU
- alu_in2  out  32  operand 2 to the ALU
- alu_op  out  8  one-hot op; 0 when idle
- alu_funct7  out  1  funct7 flag to the ALU
- wb_valid  out  1  ALU result valid this cycle
- wb_tag  out  TAG_W  tag for the ALU result this cycle

Behaviour:
- Reset is synchronous and active-high on rst; the clock is clk. On reset all slots become invalid, and wb_valid=0, wb_tag=0. Outputs therefore read issue_ready=1, alu_op=0, alu_in1=alu_in2=0, alu_funct7=0.
- Slot state: busy, op, funct7, dst_tag, and per operand {wait, tag, value}.
- issue_ready=1 iff any slot has busy=0, computed from registered state only. A slot freed by dispatch this cycle does not count until the next cycle.
- Issue: when issue_valid && issue_ready, write into the lowest-index free slot at the clock edge.
- Issue-time bypass: if issue_qN_wait && cdb_valid && cdb_tag==issue_qN_tag in the same cycle, the operand is stored with wait=0 and value=cdb_value.
- CDB snoop: every busy slot with wait=1 and tag==cdb_tag while cdb_valid captures cdb_value and clears wait at the edge. Both operands may capture from the same broadcast.
- Ready = busy && !wait1 && !wait2, using registered state. A slot completed by the CDB this cycle is eligible next cycle.
- Dispatch selection: the lowest-index ready slot.
- Dispatch outputs are combinational from registered state. For the selected slot, alu_in1/alu_in2 = values, alu_op = op, alu_funct7 = funct7.
- With no ready slot, alu_op=0 and all other ALU outputs are 0, so the ALU computes 0 and no wb is flagged.
- The ALU is never back-pressured; dispatch always succeeds. The slot's busy bit clears at the edge.
- Writeback alignment: wb_valid/wb_tag are registered copies of (dispatch_happened, dst_tag). The ALU result arrives at the same edge, giving 1-cycle latency from dispatch to wb_valid.
- Issue and dispatch may occur in the same cycle on different slots. Issue never targets the slot being dispatched.
- Full: when issue_ready=0, issue_valid is ignored and no state changes.
- A CDB tag matching no waiting operand has no effect.
- Reset mid-operation discards all slots and suppresses the pending wb_valid on the next cycle.
- Slots do not wrap or age; the ordering is purely by index.

Decomposition:
- Shared package alu_pkg:
  - Op bit index constants OP_ADD=0 through OP_AND=7 and the ALU_OP_W=8 constant.
  - rs_operand_t {wait, tag, value} and rs_slot_t typedefs.
- Sub-module rs_slot: one slot's storage, issue-time bypass and CDB capture, with a ready output.
- The top level instantiates ENTRIES slots plus two lowest-index priority pickers (free, ready).

Test Plan:
- Issue add, v1=5, v2=7, no waits, funct7=0 -> next cycle alu_op=8'h01, alu_in1=5, alu_in2=7; cycle after that wb_valid=1, wb_tag=issue tag.
- Issue sub (op=01, funct7=1) with q1 waiting on tag 3, v2=2. Drive cdb {3, 10} two cycles later. -> No dispatch before capture; dispatch the cycle after capture with alu_in1=10, alu_funct7=1; wb_valid one cycle later.
- Issue with q1 and q2 both waiting on tag 6 while cdb {6, 0x20} is valid in the same cycle -> bypass; dispatched next cycle with alu_in1=alu_in2=0x20.
- Fill all 4 slots with waiting ops -> issue_ready=0; a 5th issue_valid is ignored. Broadcast releasing slot 2 -> slot 2 dispatches, issue_ready returns the cycle after.
- Slots 1 and 3 become ready on the same CDB edge -> slot 1 dispatches first, slot 3 on the next cycle; wb_tag sequence matches.
- Assert rst the cycle after a dispatch -> wb_valid=0 on the following cycle, issue_ready=1, alu_op=0.
